pico_irq_ctrl: RTL and testbench

PICO_IRQ_CTRL -- requirements
Module: pico_irq_ctrl

---
 rtl/pico_irq_ctrl.sv | 165 ++++++++++++++++
 tb/tb_pico_irq_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pico_irq_ctrl.sv
// KCPSM3 interrupt controller: edge-detected sources plus an interval timer,
// behind an 8-port register block with a priority vector and interrupt/ack handshake.
module pico_irq_ctrl #(
  parameter int unsigned N_SRC     = 4,
  parameter logic [7:0]  BASE_ADDR = 8'h10,
  parameter int unsigned TMR_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       port_id,
  input  logic             write_strobe,
  input  logic             read_strobe,
  input  logic [7:0]       out_port,
  output logic [7:0]       in_port,
  input  logic [N_SRC-1:0] irq_src,
  output logic             interrupt,
  input  logic             interrupt_ack
);

  localparam int unsigned PW = N_SRC + 1;
  // Timer state is kept 16 bits wide; bits above TMR_W are held at zero.
  localparam logic [15:0] TmrMask = 16'((32'd1 << TMR_W) - 32'd1);

  localparam logic [2:0] OffPend = 3'd0;
  localparam logic [2:0] OffMask = 3'd1;
  localparam logic [2:0] OffVec  = 3'd2;
  localparam logic [2:0] OffCtrl = 3'd3;
  localparam logic [2:0] OffRlo  = 3'd4;
  localparam logic [2:0] OffRhi  = 3'd5;
  localparam logic [2:0] OffClo  = 3'd6;
  localparam logic [2:0] OffChi  = 3'd7;

  logic [PW-1:0]    pend_q, pend_d;
  logic [PW-1:0]    mask_q, mask_d;
  logic             gie_q, gie_d;
  logic             ten_q, ten_d;
  logic             auto_q, auto_d;
  logic [15:0]      reload_q, reload_d;
  logic [15:0]      count_q, count_d;
  logic [N_SRC-1:0] src_q;
  logic [N_SRC-1:0] blk_q, blk_d;
  logic             irq_q, irq_d;

  logic             sel;
  logic [2:0]       offset;
  logic             wr_en;
  logic [PW-1:0]    active;
  logic             vec_valid;
  logic [2:0]       vec_idx;
  logic [N_SRC-1:0] rise;
  logic             tmr_expire;
  logic [PW-1:0]    pend_clr;
  logic [PW-1:0]    ack_clr;
  logic             cnt_load;
  logic             unused_ok;

  assign sel       = (port_id[7:3] == BASE_ADDR[7:3]);
  assign offset    = port_id[2:0];
  assign wr_en     = write_strobe & sel;
  assign unused_ok = read_strobe;

  assign active = pend_q & mask_q;

  // Lowest-numbered active source wins.
  always_comb begin
    vec_valid = |active;
    vec_idx   = 3'd0;
    for (int i = int'(PW) - 1; i >= 0; i--) begin
      if (active[i]) vec_idx = 3'(i);
    end
  end

  // blk_q masks sources that were already high when reset released until they drop.
  assign rise       = irq_src & ~src_q & ~blk_q;
  assign tmr_expire = ten_q && (count_q == 16'd0);
  assign ack_clr    = (interrupt_ack && vec_valid) ? (PW'(1) << vec_idx) : '0;

  always_comb begin
    mask_d   = mask_q;
    gie_d    = gie_q;
    ten_d    = ten_q;
    auto_d   = auto_q;
    reload_d = reload_q;
    count_d  = count_q;
    pend_clr = '0;
    cnt_load = 1'b0;

    if (ten_q) begin
      if (count_q == 16'd0) count_d = reload_q;
      else                  count_d = count_q - 16'd1;
    end
    if (tmr_expire && !auto_q) ten_d = 1'b0;

    // Register writes are applied after the timer so a CTRL write wins over expiry.
    if (wr_en) begin
      case (offset)
        OffPend: pend_clr = out_port[PW-1:0];
        OffMask: mask_d   = out_port[PW-1:0];
        OffCtrl: begin
          gie_d    = out_port[0];
          ten_d    = out_port[1];
          auto_d   = out_port[2];
          cnt_load = out_port[1];
        end
        OffRlo:  reload_d = {reload_q[15:8], out_port} & TmrMask;
        OffRhi: begin
          reload_d = {out_port, reload_q[7:0]} & TmrMask;
          cnt_load = 1'b1;
        end
        default: ;
      endcase
    end
    if (cnt_load) count_d = reload_d;

    // Set events take precedence over W1C and ack clears.
    pend_d = (pend_q & ~pend_clr & ~ack_clr) | {tmr_expire, rise};
    blk_d  = blk_q & irq_src;
    irq_d  = gie_q & (|active);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q   <= '0;
      mask_q   <= '0;
      gie_q    <= 1'b0;
      ten_q    <= 1'b0;
      auto_q   <= 1'b0;
      reload_q <= '0;
      count_q  <= '0;
      src_q    <= '0;
      blk_q    <= '1;
      irq_q    <= 1'b0;
    end else begin
      pend_q   <= pend_d;
      mask_q   <= mask_d;
      gie_q    <= gie_d;
      ten_q    <= ten_d;
      auto_q   <= auto_d;
      reload_q <= reload_d;
      count_q  <= count_d;
      src_q    <= irq_src;
      blk_q    <= blk_d;
      irq_q    <= irq_d;
    end
  end

  assign interrupt = irq_q;

  always_comb begin
    in_port = 8'h00;
    if (sel) begin
      unique case (offset)
        OffPend: in_port = 8'(pend_q);
        OffMask: in_port = 8'(mask_q);
        OffVec:  in_port = {vec_valid, 4'b0000, vec_idx};
        OffCtrl: in_port = {5'b00000, auto_q, ten_q, gie_q};
        OffRlo:  in_port = reload_q[7:0];
        OffRhi:  in_port = reload_q[15:8];
        OffClo:  in_port = count_q[7:0];
        OffChi:  in_port = count_q[15:8];
      endcase
    end
  end

endmodule

// File: tb/tb_pico_irq_ctrl.sv
// Directed bench for pico_irq_ctrl: register map, edge capture, priority vector,
// ack handshake, interval timer and reset behaviour.
module tb_pico_irq_ctrl;

  localparam logic [7:0] B = 8'h10;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] port_id;
  logic       write_strobe;
  logic       read_strobe;
  logic [7:0] out_port;
  logic [7:0] in_port;
  logic [3:0] irq_src;
  logic       interrupt;
  logic       interrupt_ack;

  int n_cmp = 0;
  int n_bad = 0;

  pico_irq_ctrl #(.N_SRC(4), .BASE_ADDR(8'h10), .TMR_W(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .port_id      (port_id),
    .write_strobe (write_strobe),
    .read_strobe  (read_strobe),
    .out_port     (out_port),
    .in_port      (in_port),
    .irq_src      (irq_src),
    .interrupt    (interrupt),
    .interrupt_ack(interrupt_ack)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // All helpers start and end at a falling edge.
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] off, input logic [7:0] d);
    port_id      = B | 8'(off);
    out_port     = d;
    write_strobe = 1'b1;
    @(negedge clk);
    write_strobe = 1'b0;
    port_id      = 8'h00;
  endtask

  task automatic rd(input logic [2:0] off, output logic [7:0] d);
    port_id     = B | 8'(off);
    read_strobe = 1'b1;
    #1;
    d           = in_port;
    read_strobe = 1'b0;
    port_id     = 8'h00;
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    irq_src       = '0;
    interrupt_ack = 1'b0;
    write_strobe  = 1'b0;
    cyc(2);
    reset = 1'b0;
    cyc(1);
  endtask

  task automatic test_reset();
    logic [7:0] v;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      rd(3'(i), v);
      if (v !== 8'h00) begin
        n_bad++; $display("FAIL reset_reg%0d: got %02h want 00", i, v);
      end
      n_cmp++;
      cyc(1);
    end
    if (interrupt !== 1'b0) begin
      n_bad++; $display("FAIL reset_irq: got %b want 0", interrupt);
    end
    n_cmp++;
  endtask

  task automatic test_single();
    logic [7:0] v;
    do_reset();
    wr(3'd1, 8'h01);
    wr(3'd3, 8'h01);
    irq_src = 4'b0001;
    cyc(1);
    irq_src = 4'b0000;
    rd(3'd0, v);
    if (v !== 8'h01) begin n_bad++; $display("FAIL s1_pend: got %02h want 01", v); end
    n_cmp++;
    rd(3'd2, v);
    if (v !== 8'h80) begin n_bad++; $display("FAIL s1_vec: got %02h want 80", v); end
    n_cmp++;
    if (interrupt !== 1'b0) begin n_bad++; $display("FAIL s1_irq_lag: got %b want 0", interrupt); end
    n_cmp++;
    cyc(1);
    if (interrupt !== 1'b1) begin n_bad++; $display("FAIL s1_irq: got %b want 1", interrupt); end
    n_cmp++;
    interrupt_ack = 1'b1;
    cyc(1);
    interrupt_ack = 1'b0;
    rd(3'd0, v);
    if (v !== 8'h00) begin n_bad++; $display("FAIL s1_ack_pend: got %02h want 00", v); end
    n_cmp++;
    cyc(1);
    if (interrupt !== 1'b0) begin n_bad++; $display("FAIL s1_irq_drop: got %b want 0", interrupt); end
    n_cmp++;
  endtask

  task automatic test_priority();
    logic [7:0] v;
    do_reset();
    wr(3'd1, 8'h0F);
    irq_src = 4'b1010;
    cyc(1);
    irq_src = 4'b0000;
    rd(3'd2, v);
    if (v !== 8'h81) begin n_bad++; $display("FAIL s2_vec1: got %02h want 81", v); end
    n_cmp++;
    interrupt_ack = 1'b1;
    cyc(1);
    interrupt_ack = 1'b0;
    rd(3'd2, v);
    if (v !== 8'h83) begin n_bad++; $display("FAIL s2_vec3: got %02h want 83", v); end
    n_cmp++;
    rd(3'd0, v);
    if (v !== 8'h08) begin n_bad++; $display("FAIL s2_pend: got %02h want 08", v); end
    n_cmp++;
    interrupt_ack = 1'b1;
    cyc(1);
    interrupt_ack = 1'b0;
    rd(3'd2, v);
    if (v !== 8'h00) begin n_bad++; $display("FAIL s2_vec0: got %02h want 00", v); end
    n_cmp++;
    // Ack with nothing valid must leave a masked-off pending bit alone.
    wr(3'd1, 8'h00);
    irq_src = 4'b0001;
    cyc(1);
    irq_src = 4'b0000;
    interrupt_ack = 1'b1;
    cyc(1);
    interrupt_ack = 1'b0;
    rd(3'd0, v);
    if (v !== 8'h01) begin n_bad++; $display("FAIL s2_ack_invalid: got %02h want 01", v); end
    n_cmp++;
  endtask

  task automatic test_timer_auto();
    logic [7:0] v;
    int n;
    do_reset();
    wr(3'd4, 8'd9);
    wr(3'd3, 8'h07);
    n = 0; v = 8'h00;
    while (v[4] == 1'b0 && n < 30) begin cyc(1); n++; rd(3'd0, v); end
    if (n != 10) begin n_bad++; $display("FAIL s3_first_period: got %0d want 10", n); end
    n_cmp++;
    rd(3'd6, v);
    if (v !== 8'd9) begin n_bad++; $display("FAIL s3_reload: got %02h want 09", v); end
    n_cmp++;
    wr(3'd0, 8'h10);
    n = 1; v = 8'h00;
    while (v[4] == 1'b0 && n < 30) begin cyc(1); n++; rd(3'd0, v); end
    if (n != 10) begin n_bad++; $display("FAIL s3_period: got %0d want 10", n); end
    n_cmp++;
    rd(3'd3, v);
    if (v !== 8'h07) begin n_bad++; $display("FAIL s3_ctrl: got %02h want 07", v); end
    n_cmp++;
  endtask

  task automatic test_timer_oneshot();
    logic [7:0] v;
    int n;
    do_reset();
    wr(3'd4, 8'd9);
    wr(3'd3, 8'h03);
    n = 0; v = 8'h00;
    while (v[4] == 1'b0 && n < 30) begin cyc(1); n++; rd(3'd0, v); end
    if (n != 10) begin n_bad++; $display("FAIL s3_oneshot_period: got %0d want 10", n); end
    n_cmp++;
    rd(3'd3, v);
    if (v !== 8'h01) begin n_bad++; $display("FAIL s3_oneshot_ctrl: got %02h want 01", v); end
    n_cmp++;
    wr(3'd0, 8'h10);
    cyc(15);
    rd(3'd0, v);
    if (v !== 8'h00) begin n_bad++; $display("FAIL s3_oneshot_once: got %02h want 00", v); end
    n_cmp++;
    rd(3'd6, v);
    if (v !== 8'd9) begin n_bad++; $display("FAIL s3_count_held: got %02h want 09", v); end
    n_cmp++;
    wr(3'd5, 8'h12);
    rd(3'd7, v);
    if (v !== 8'h12) begin n_bad++; $display("FAIL rhi_load_chi: got %02h want 12", v); end
    n_cmp++;
    rd(3'd5, v);
    if (v !== 8'h12) begin n_bad++; $display("FAIL rhi_readback: got %02h want 12", v); end
    n_cmp++;
  endtask

  task automatic test_w1c_vs_set();
    logic [7:0] v;
    do_reset();
    port_id      = B;
    out_port     = 8'h04;
    write_strobe = 1'b1;
    irq_src      = 4'b0100;
    cyc(1);
    write_strobe = 1'b0;
    port_id      = 8'h00;
    rd(3'd0, v);
    if (v !== 8'h04) begin n_bad++; $display("FAIL s4_set_wins: got %02h want 04", v); end
    n_cmp++;
    wr(3'd0, 8'h04);
    cyc(2);
    rd(3'd0, v);
    if (v !== 8'h00) begin n_bad++; $display("FAIL s4_level_once: got %02h want 00", v); end
    n_cmp++;
    irq_src = 4'b0000;
  endtask

  task automatic test_mask_gate();
    do_reset();
    wr(3'd3, 8'h01);
    wr(3'd1, 8'h00);
    irq_src = 4'b0100;
    cyc(1);
    irq_src = 4'b0000;
    cyc(2);
    if (interrupt !== 1'b0) begin n_bad++; $display("FAIL s5_masked: got %b want 0", interrupt); end
    n_cmp++;
    wr(3'd1, 8'h04);
    if (interrupt !== 1'b0) begin n_bad++; $display("FAIL s5_lag: got %b want 0", interrupt); end
    n_cmp++;
    cyc(1);
    if (interrupt !== 1'b1) begin n_bad++; $display("FAIL s5_unmasked: got %b want 1", interrupt); end
    n_cmp++;
    wr(3'd3, 8'h00);
    cyc(1);
    if (interrupt !== 1'b0) begin n_bad++; $display("FAIL s5_gie_off: got %b want 0", interrupt); end
    n_cmp++;
  endtask

  task automatic test_reset_mid();
    logic [7:0] v;
    do_reset();
    wr(3'd1, 8'h1F);
    wr(3'd4, 8'h03);
    wr(3'd3, 8'h07);
    irq_src = 4'hF;
    cyc(1);
    irq_src = 4'h0;
    cyc(4);
    rd(3'd0, v);
    if (v !== 8'h1F) begin n_bad++; $display("FAIL s6_pend_full: got %02h want 1f", v); end
    n_cmp++;
    // Reset collides with a write, an ack and fresh source edges.
    reset         = 1'b1;
    port_id       = B | 8'h01;
    out_port      = 8'hFF;
    write_strobe  = 1'b1;
    interrupt_ack = 1'b1;
    irq_src       = 4'hF;
    cyc(1);
    reset         = 1'b0;
    write_strobe  = 1'b0;
    interrupt_ack = 1'b0;
    port_id       = 8'h00;
    if (interrupt !== 1'b0) begin n_bad++; $display("FAIL s6_irq: got %b want 0", interrupt); end
    n_cmp++;
    for (int i = 0; i < 8; i++) begin
      rd(3'(i), v);
      if (v !== 8'h00) begin n_bad++; $display("FAIL s6_reg%0d: got %02h want 00", i, v); end
      n_cmp++;
      cyc(1);
    end
    irq_src = 4'hE;
    cyc(1);
    irq_src = 4'hF;
    cyc(1);
    rd(3'd0, v);
    if (v !== 8'h01) begin n_bad++; $display("FAIL s6_rearm: got %02h want 01", v); end
    n_cmp++;
    irq_src = 4'h0;
    port_id = 8'h18;
    #1;
    if (in_port !== 8'h00) begin n_bad++; $display("FAIL s6_unsel_18: got %02h want 00", in_port); end
    n_cmp++;
    port_id = 8'h0F;
    #1;
    if (in_port !== 8'h00) begin n_bad++; $display("FAIL s6_unsel_0f: got %02h want 00", in_port); end
    n_cmp++;
    cyc(1);
    wr(3'd0, 8'h00);
    port_id      = 8'h21;
    out_port     = 8'hFF;
    write_strobe = 1'b1;
    cyc(1);
    write_strobe = 1'b0;
    rd(3'd1, v);
    if (v !== 8'h00) begin n_bad++; $display("FAIL s6_unsel_write: got %02h want 00", v); end
    n_cmp++;
  endtask

  initial begin
    reset         = 1'b1;
    port_id       = 8'h00;
    write_strobe  = 1'b0;
    read_strobe   = 1'b0;
    out_port      = 8'h00;
    irq_src       = '0;
    interrupt_ack = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_priority();
    test_timer_auto();
    test_timer_oneshot();
    test_w1c_vs_set();
    test_mask_gate();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
